// File: rtl/speed_uart_tx.sv
// speed_uart_tx
// Captures a measured speed on the `done` pulse, converts it to five ASCII
// decimal digits with a sequential double-dabble, and sends "DDDDD\r\n" as
// back-to-back 8N1 UART frames on serial_data_out. One message in flight at
// a time; requests arriving while busy are reported on `drop` and ignored.

module speed_uart_tx #(
    parameter int SYS_FREQ    = 10000000,
    parameter int BAUD        = 115200,
    parameter int WIDTH_SPEED = 14
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic                   done,
    output logic                   serial_data_out,
    output logic                   busy,
    output logic                   drop
);

    localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CONV_W       = $clog2(WIDTH_SPEED + 2);
    localparam int DD_W         = 20 + WIDTH_SPEED;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CONV_W-1:0] CONV_SHIFTS = CONV_W'(WIDTH_SPEED);
    localparam logic [CONV_W-1:0] CONV_LOAD   = CONV_W'(WIDTH_SPEED + 1);
    localparam logic [2:0]        LAST_BYTE   = 3'd6;
    localparam logic [2:0]        LAST_BIT    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CONVERT    = 3'd1,
        ST_SEND_START = 3'd2,
        ST_SEND_DATA  = 3'd3,
        ST_SEND_STOP  = 3'd4,
        ST_NEXT_BYTE  = 3'd5
    } state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        logic [3:0]  nib;
        res = 20'h0_0000;
        for (int n = 0; n < 5; n++) begin
            nib = bcd[4*n +: 4];
            if (nib >= 4'd5) begin
                res[4*n +: 4] = nib + 4'd3;
            end else begin
                res[4*n +: 4] = nib;
            end
        end
        return res;
    endfunction

    // One BCD digit to its ASCII character.
    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        return 8'h30 + {4'h0, nib};
    endfunction

    // Seven-byte message, byte 0 (most significant digit) in the low byte so
    // that a right shift by 8 advances to the next byte.
    function automatic logic [55:0] build_msg(input logic [19:0] bcd);
        return {8'h0A, 8'h0D,
                digit_ascii(bcd[3:0]),   digit_ascii(bcd[7:4]),
                digit_ascii(bcd[11:8]),  digit_ascii(bcd[15:12]),
                digit_ascii(bcd[19:16])};
    endfunction

    state_t                   state_q,    state_d;
    logic [WIDTH_SPEED-1:0]   bin_q,      bin_d;
    logic [19:0]              bcd_q,      bcd_d;
    logic [CONV_W-1:0]        conv_cnt_q, conv_cnt_d;
    logic [BAUD_W-1:0]        baud_q,     baud_d;
    logic [2:0]               bit_idx_q,  bit_idx_d;
    logic [2:0]               byte_idx_q, byte_idx_d;
    logic [55:0]              msg_q,      msg_d;
    logic                     tx_q,       tx_d;
    logic                     busy_q,     busy_d;
    logic                     drop_q,     drop_d;

    logic                     baud_end_s;
    logic                     capture_s;
    logic [7:0]               byte_s;
    logic [DD_W-1:0]          dd_s;

    // State register and all datapath registers; reset returns the line to idle-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= 20'h0_0000;
            conv_cnt_q <= '0;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            msg_q      <= 56'h0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            conv_cnt_q <= conv_cnt_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            msg_q      <= msg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state and next-output logic; the line value is registered together
    // with the state it belongs to, so the pin changes on the same edge.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        conv_cnt_d = conv_cnt_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        msg_d      = msg_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        drop_d     = 1'b0;
        capture_s  = 1'b0;
        baud_end_s = (baud_q == BAUD_LAST);
        byte_s     = msg_q[7:0];
        dd_s       = {dabble_adjust(bcd_q), bin_q} << 1'b1;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (done) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end

            // WIDTH_SPEED shift cycles, then one settle cycle and one load
            // cycle so the start bit lands WIDTH_SPEED+2 edges after capture.
            ST_CONVERT: begin
                if (conv_cnt_q < CONV_SHIFTS) begin
                    bcd_d      = dd_s[DD_W-1:WIDTH_SPEED];
                    bin_d      = dd_s[WIDTH_SPEED-1:0];
                    conv_cnt_d = conv_cnt_q + {{(CONV_W-1){1'b0}}, 1'b1};
                end else if (conv_cnt_q < CONV_LOAD) begin
                    conv_cnt_d = conv_cnt_q + {{(CONV_W-1){1'b0}}, 1'b1};
                end else begin
                    msg_d      = build_msg(bcd_q);
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    baud_d     = '0;
                    tx_d       = 1'b0;
                    state_d    = ST_SEND_START;
                end
            end

            ST_SEND_START: begin
                if (baud_end_s) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = byte_s[0];
                    state_d   = ST_SEND_DATA;
                end else begin
                    baud_d = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end

            ST_SEND_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_SEND_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = byte_s[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end

            // The byte-advance decision is folded into the last stop-bit
            // cycle so consecutive frames have no idle gap between them.
            ST_SEND_STOP: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        msg_d      = {8'h00, msg_q[55:8]};
                        tx_d       = 1'b0;
                        state_d    = ST_SEND_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                        if (done) begin
                            capture_s = 1'b1;
                        end else begin
                            capture_s = 1'b0;
                        end
                    end
                end else begin
                    baud_d = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end

            // NEXT_BYTE is resolved inside SEND_STOP and never held; reaching
            // it (or any undefined encoding) means corruption, so recover to idle.
            ST_NEXT_BYTE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (capture_s) begin
            bin_d      = speed;
            bcd_d      = 20'h0_0000;
            conv_cnt_d = '0;
            busy_d     = 1'b1;
            tx_d       = 1'b1;
            state_d    = ST_CONVERT;
        end else begin
            drop_d = done && (state_q != ST_IDLE);
        end
    end

    assign serial_data_out = tx_q;
    assign busy            = busy_q;
    assign drop            = drop_q;

endmodule

// File: tb/tb_speed_uart_tx.sv
// Self-checking bench for speed_uart_tx. The expected line waveform is derived
// from decimal arithmetic on the speed value and the 8N1 frame layout; every
// message is logged cycle by cycle and compared against that waveform.

module tb_speed_uart_tx;

    localparam int SYS_FREQ = 10000000;
    localparam int BAUD     = 115200;
    localparam int W        = 14;
    localparam int C        = SYS_FREQ / BAUD;
    localparam int FRAME    = 10 * C;
    localparam int LAT      = W + 2;
    localparam int ENDC     = LAT + 7 * FRAME;
    localparam int TAIL     = 40;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         done    = 1'b0;
    logic [W-1:0] speed   = '0;
    logic         serial_data_out;
    logic         busy;
    logic         drop;

    int n_cmp = 0;
    int n_bad = 0;

    speed_uart_tx #(
        .SYS_FREQ   (SYS_FREQ),
        .BAUD       (BAUD),
        .WIDTH_SPEED(W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .speed          (speed),
        .done           (done),
        .serial_data_out(serial_data_out),
        .busy           (busy),
        .drop           (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte k of the message for value v ("DDDDD\r\n").
    function automatic logic [7:0] exp_byte(input int v, input int k);
        int p;
        if (k == 5) return 8'h0D;
        if (k == 6) return 8'h0A;
        p = 1;
        for (int j = 0; j < 4 - k; j++) p = p * 10;
        return 8'(48 + (v / p) % 10);
    endfunction

    // Reference: line level i cycles after the capture edge.
    function automatic logic exp_line(input int v, input int i);
        int o, k, pos;
        logic [7:0] b;
        if (i < LAT || i >= ENDC) return 1'b1;
        o   = i - LAT;
        k   = o / FRAME;
        pos = (o % FRAME) / C;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = exp_byte(v, k);
        return b[pos-1];
    endfunction

    // Send one request and follow the whole message cycle by cycle.
    //   inj_at/inj_len : extra done cycles while busy (expect that many drops)
    //   rst_at         : cycle at which reset is pulled (message abandoned)
    //   early          : stop one cycle before the end so the caller can chain
    task automatic run_msg(input int val, input int inj_at, input int inj_len,
                           input int rst_at, input bit early);
        logic    lq[$];
        int      line_err = 0;
        int      busy_err = 0;
        int      drops    = 0;
        int      last;
        bit      aborted  = 1'b0;
        logic [7:0] rx;
        last  = early ? ENDC - 1 : ENDC + TAIL;
        speed = W'(val);
        done  = 1'b1;
        for (int i = 0; i <= last; i++) begin
            @(posedge clk);
            #1;
            lq.push_back(serial_data_out);
            if (serial_data_out !== exp_line(val, i)) line_err++;
            if (busy !== ((i < ENDC) ? 1'b1 : 1'b0)) busy_err++;
            if (drop === 1'b1) drops++;
            if (i == 0) speed = W'($urandom);
            done = (i >= inj_at && i < inj_at + inj_len) ? 1'b1 : 1'b0;
            if (i == rst_at) begin
                reset_n = 1'b0;
                #2;
                check("rst_line_async", serial_data_out, 1);
                check("rst_busy_async", busy, 0);
                check("rst_drop_async", drop, 0);
                repeat (3) @(posedge clk);
                #1;
                check("rst_line_held", serial_data_out, 1);
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            for (int k = 0; k < 7; k++) begin
                rx = 8'h00;
                for (int b = 0; b < 8; b++) rx[b] = lq[LAT + k * FRAME + (b + 1) * C + C / 2];
                check($sformatf("v%0d_byte%0d", val, k), rx, exp_byte(val, k));
            end
            check($sformatf("v%0d_line_timing_errs", val), line_err, 0);
            check($sformatf("v%0d_busy_errs", val), busy_err, 0);
            check($sformatf("v%0d_drop_cycles", val), drops, inj_len);
        end
    endtask

    initial begin
        int r;
        // Reset state, during and just after reset.
        repeat (3) @(posedge clk);
        #1;
        check("reset_line", serial_data_out, 1);
        check("reset_busy", busy, 0);
        check("reset_drop", drop, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_line", serial_data_out, 1);
        check("idle_busy", busy, 0);

        // Directed values: all zeros, maximum, small value with leading zeros.
        run_msg(0,     -1, 0, -1, 1'b0);
        run_msg(16383, -1, 0, -1, 1'b0);
        run_msg(72,    -1, 0, -1, 1'b0);

        // Random value.
        r = int'($urandom_range(0, 16383));
        run_msg(r, -1, 0, -1, 1'b0);

        // Second request 1000 cycles in: one drop, message undisturbed.
        r = int'($urandom_range(0, 16383));
        run_msg(r, 1000, 1, -1, 1'b0);

        // done held three cycles while busy: three drop cycles.
        r = int'($urandom_range(0, 16383));
        run_msg(r, 2000, 3, -1, 1'b0);

        // Reset during data bits of byte 3, then a clean message.
        r = int'($urandom_range(0, 16383));
        run_msg(r, -1, 0, LAT + 3 * FRAME + 3 * C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        r = int'($urandom_range(0, 16383));
        run_msg(r, -1, 0, -1, 1'b0);

        // done on the exact edge busy falls: accepted, no drop.
        r = int'($urandom_range(0, 16383));
        run_msg(r, -1, 0, -1, 1'b1);
        run_msg(5, -1, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/speed_uart_tx.md
Name: speed_uart_tx

Overview:
Downstream stage of the speed-measurement path in the toll/speed-check top. It captures each measured speed value on the `done` pulse from the speed calculator. It converts the value to 5 ASCII decimal digits using sequential double-dabble and transmits "DDDDD\r\n" as 8N1 UART frames on `serial_data_out`. This is the only source of the top-level `serial_data_out` pin.

Parameters:
- SYS_FREQ, 10000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = SYS_FREQ/BAUD (integer division; 86 at defaults).
- WIDTH_SPEED, 14, width of the speed input; legal range 1..16 so that 5 digits always suffice.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- speed  input  WIDTH_SPEED  unsigned speed value, valid while done=1.
- done  input  1  single-cycle pulse: speed valid, capture request.
- serial_data_out  output  1  UART TX line, 8N1, LSB first, idle high.
- busy  output  1  high from capture until the stop bit of the LF byte completes.
- drop  output  1  one-cycle pulse when done arrives while busy.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - serial_data_out=1, busy=0, drop=0.
  - FSM returns to IDLE; all counters and shift registers are cleared.
- FSM states: IDLE, CONVERT, SEND_START, SEND_DATA, SEND_STOP, NEXT_BYTE.
- IDLE:
  - On done=1, latch speed into the binary shift register and clear the 20-bit BCD register.
  - Set busy=1 on the next edge, then go to CONVERT.
- CONVERT: double-dabble, one bit per cycle, exactly WIDTH_SPEED cycles.
  - Each cycle: add 3 to every BCD nibble >=5, then shift left by one, bringing in the binary MSB.
  - After the final shift, load the 7-byte message:
    - d4..d0 = 0x30 + BCD nibble (most significant digit first).
    - then 0x0D, then 0x0A.
  - Leading zeros are always sent.
  - Go to SEND_START.
- Latency: serial_data_out goes low exactly WIDTH_SPEED+2 rising edges after the edge that sampled done=1 (16 cycles at defaults).
- Bit timing: each of start, 8 data bits and stop is held exactly CLKS_PER_BIT cycles.
  - Baud counter runs 0..CLKS_PER_BIT-1 and is reset at the start of every bit.
- SEND_START: line=0 for one bit period, then SEND_DATA.
- SEND_DATA: bits 0..7 of the current byte, LSB first; a 3-bit index counter runs 0..7, then SEND_STOP.
- SEND_STOP: line=1 for one bit period, then NEXT_BYTE.
- NEXT_BYTE: takes zero bit-time.
  - Byte index 0..6. If index<6, increment it and go to SEND_START in the same cycle as the stop bit ends, so bytes are back-to-back with no idle gap.
  - If index=6, clear busy and go to IDLE.
- Frame and message length: 10 bits per byte; whole message = 70*CLKS_PER_BIT cycles (6020 at defaults).
- busy deasserts on the edge where the last stop bit period ends.
- A done arriving in that same cycle counts as IDLE (accepted, not dropped).
- done while busy=1: request is ignored and drop pulses high for exactly one cycle.
  - The ongoing conversion or transmission is unaffected.
  - done held high for N cycles while busy gives N drop cycles.
- done held high in IDLE: only the first cycle is captured; subsequent high cycles fall under the busy rule.
- speed is sampled only on the capture cycle; changes afterwards have no effect.
- No parity, no flow control, no input FIFO: one message in flight at a time.

Test Plan:
- speed=0, done pulse → bytes 0x30,0x30,0x30,0x30,0x30,0x0D,0x0A. Start bit falls 16 cycles after done; busy high for 16+6020 cycles.
- speed=16383 (max for 14 bits) → bytes 0x31,0x36,0x33,0x38,0x33,0x0D,0x0A. Each bit measured as exactly 86 cycles wide.
- speed=72 → "00072\r\n", i.e. 0x30,0x30,0x30,0x37,0x32,0x0D,0x0A. Line stays high between messages and no idle gap appears between bytes.
- Second done 1000 cycles after the first (busy) → drop=1 for exactly 1 cycle; first message is bit-identical to the undisturbed case; no second message.
- reset_n pulled low during the data bits of byte 3 → serial_data_out=1 and busy=0 immediately. A new done after release transmits a complete, correct message.
- done asserted on the exact cycle busy falls with speed=5 → accepted with drop=0. "00005\r\n" starts 16 cycles later.
